// File: rtl/code_query_fsm.sv
// code_query_fsm: initiator side of the code lookup. Latches a keypad code,
// queries the code database for a fixed latency, then pulses grant or deny.
// Wrong codes are counted; MAX_TRIES in a row trigger a timed lockout.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   key_valid/key_code keypad strobe and 4-bit code
//   db_match           database result, valid DB_LATENCY cycles after query
//   db_enable/db_code  query request and code towards the database
//   grant/deny         one-cycle result pulses to the brew controller
//   busy/locked        not-idle and lockout status
//   try_count          consecutive failed attempts (saturating)
module code_query_fsm #(
    parameter int DB_LATENCY  = 1,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             db_match,
    output logic                             db_enable,
    output logic [3:0]                       db_code,
    output logic                             grant,
    output logic                             deny,
    output logic                             busy,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   try_count
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int WW = (DB_LATENCY > 1) ? $clog2(DB_LATENCY) : 1;
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    localparam logic [WW-1:0] WLAST = WW'(DB_LATENCY - 1);
    localparam logic [LW-1:0] LLAST = LW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        WAIT,
        RESULT,
        LOCKOUT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          match_q;
    logic [TW-1:0] try_inc;
    logic          wait_done;
    logic          lock_done;

    assign wait_done = (wait_cnt == WLAST);
    assign lock_done = (lock_cnt == LLAST);

    // Saturating increment; the counter never wraps.
    assign try_inc = (try_count == TMAX) ? TMAX
                                         : try_count + TW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        db_enable = 1'b0;
        grant     = 1'b0;
        deny      = 1'b0;
        locked    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (key_valid) begin
                    state_n = QUERY;
                end
            end
            QUERY: begin
                db_enable = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                db_enable = 1'b1;
                if (wait_done) begin
                    state_n = RESULT;
                end
            end
            RESULT: begin
                if (match_q) begin
                    grant   = 1'b1;
                    state_n = IDLE;
                end else begin
                    deny    = 1'b1;
                    state_n = (try_inc == TMAX) ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: begin
                locked = 1'b1;
                if (lock_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_code   <= 4'b0000;
            wait_cnt  <= '0;
            lock_cnt  <= '0;
            match_q   <= 1'b0;
            try_count <= '0;
        end else begin
            if (state == IDLE && key_valid) begin
                db_code <= key_code;
            end
            if (state == QUERY) begin
                wait_cnt <= '0;
            end else if (state == WAIT && !wait_done) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            // Only the last WAIT cycle carries a valid db_match.
            if (state == WAIT && wait_done) begin
                match_q <= db_match;
            end
            if (state == RESULT) begin
                try_count <= match_q ? '0 : try_inc;
            end
            if (state == LOCKOUT && lock_done) begin
                try_count <= '0;
            end
            if (state != LOCKOUT) begin
                lock_cnt <= '0;
            end else if (!lock_done) begin
                lock_cnt <= lock_cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_query_fsm.sv
// tb_code_query_fsm: directed bench for code_query_fsm with one
// DB_LATENCY=1 instance and one DB_LATENCY=3 instance.
module tb_code_query_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid, kv3;
    logic [3:0] key_code, kc3;
    logic       db_match, dm3;

    logic       db_enable, en3;
    logic [3:0] db_code, code3;
    logic       grant, deny, busy, locked;
    logic       g3, d3, b3, l3;
    logic [1:0] try_count, tc3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    code_query_fsm #(
        .DB_LATENCY (1),
        .MAX_TRIES  (3),
        .LOCK_CYCLES(20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .db_match (db_match),
        .db_enable(db_enable),
        .db_code  (db_code),
        .grant    (grant),
        .deny     (deny),
        .busy     (busy),
        .locked   (locked),
        .try_count(try_count)
    );

    code_query_fsm #(
        .DB_LATENCY (3),
        .MAX_TRIES  (3),
        .LOCK_CYCLES(20)
    ) dut3 (
        .clk      (clk),
        .reset    (reset),
        .key_valid(kv3),
        .key_code (kc3),
        .db_match (dm3),
        .db_enable(en3),
        .db_code  (code3),
        .grant    (g3),
        .deny     (d3),
        .busy     (b3),
        .locked   (l3),
        .try_count(tc3)
    );

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One lookup on the latency-1 instance; ends in cycle t+4.
    task automatic q1(input logic [3:0] c, input logic m,
                      input logic [1:0] tc, input logic lk);
        key_code  = c;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        chk("query_en", db_enable, 1);
        chk("query_code", db_code, c);
        chk("query_busy", busy, 1);
        cyc();
        chk("wait_en", db_enable, 1);
        db_match = m;
        cyc();
        db_match = 1'b0;
        chk("res_en", db_enable, 0);
        chk("res_grant", grant, m);
        chk("res_deny", deny, !m);
        cyc();
        chk("post_grant", grant, 0);
        chk("post_deny", deny, 0);
        chk("post_try", try_count, tc);
        chk("post_locked", locked, lk);
        chk("post_busy", busy, lk);
    endtask

    // Lookup on the latency-3 instance; db_match=1 only in WAIT cycle mpos.
    task automatic q3(input logic [3:0] c, input int mpos,
                      input logic g, input logic [1:0] tc);
        kc3 = c;
        kv3 = 1'b1;
        cyc();
        kv3 = 1'b0;
        chk("l3_query_en", en3, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("l3_wait_en", en3, 1);
            chk("l3_wait_code", code3, c);
            chk("l3_wait_grant", g3, 0);
            dm3 = (k == mpos);
        end
        cyc();
        dm3 = 1'b0;
        chk("l3_res_en", en3, 0);
        chk("l3_res_grant", g3, g);
        chk("l3_res_deny", d3, !g);
        cyc();
        chk("l3_post_try", tc3, tc);
        chk("l3_post_busy", b3, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"}, db_enable, 0);
        chk({tag, "_code"}, db_code, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_deny"}, deny, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_try"}, try_count, 0);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        db_match  = 1'b0;
        kv3       = 1'b0;
        kc3       = 4'h0;
        dm3       = 1'b0;
        cyc();
        cyc();
        chk_reset_vals("rst");
        chk("rst_l3_try", tc3, 0);
        chk("rst_l3_busy", b3, 0);
        reset = 1'b0;
        cyc();

        // Correct code, then two wrong codes.
        q1(4'b1110, 1'b1, 2'd0, 1'b0);
        q1(4'b0101, 1'b0, 2'd1, 1'b0);
        q1(4'b0011, 1'b0, 2'd2, 1'b0);
        // db_code holds its value while idle.
        chk("idle_code_hold", db_code, 4'b0011);

        // Third wrong code locks; we are now in lockout cycle 1.
        q1(4'b1001, 1'b0, 2'd3, 1'b1);
        for (int i = 2; i <= 20; i++) begin
            key_code  = 4'b1110;
            key_valid = (i >= 3 && i <= 6);
            cyc();
            chk("lock_locked", locked, 1);
            chk("lock_en", db_enable, 0);
            chk("lock_try", try_count, 3);
        end
        key_valid = 1'b0;
        cyc();
        chk("unlock_locked", locked, 0);
        chk("unlock_try", try_count, 0);
        chk("unlock_busy", busy, 0);
        chk("unlock_en", db_enable, 0);

        // Two wrong, then correct resets the count.
        q1(4'b0101, 1'b0, 2'd1, 1'b0);
        q1(4'b0110, 1'b0, 2'd2, 1'b0);
        q1(4'b1110, 1'b1, 2'd0, 1'b0);
        q1(4'b0000, 1'b0, 2'd1, 1'b0);

        // Latency-3 instance: match only on last WAIT cycle counts.
        q3(4'b1110, 3, 1'b1, 2'd0);
        q3(4'b1110, 1, 1'b0, 2'd1);

        // Reset during WAIT (try_count is 1 here).
        key_code  = 4'b1010;
        key_valid = 1'b1;
        cyc();
        key_valid = 1'b0;
        cyc();
        chk("pre_rst_wait_en", db_enable, 1);
        db_match = 1'b1;
        reset    = 1'b1;
        cyc();
        db_match = 1'b0;
        chk_reset_vals("rst_wait");
        reset = 1'b0;
        cyc();
        chk("after_rst_wait_grant", grant, 0);
        chk("after_rst_wait_deny", deny, 0);
        chk("after_rst_wait_busy", busy, 0);

        // Reset during LOCKOUT.
        q1(4'b0001, 1'b0, 2'd1, 1'b0);
        q1(4'b0010, 1'b0, 2'd2, 1'b0);
        q1(4'b0100, 1'b0, 2'd3, 1'b1);
        cyc();
        cyc();
        chk("pre_rst_lock", locked, 1);
        reset = 1'b1;
        cyc();
        chk_reset_vals("rst_lock");
        reset = 1'b0;
        cyc();
        chk("after_rst_lock_busy", busy, 0);

        // Fresh lookup completes normally.
        q1(4'b1110, 1'b1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
